// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin arbiter that feeds one shared serializer.
// Requesters offer a word plus a valid-bit count. Words with a count of 1 or 2
// cannot be serialized, so they are accepted and dropped. Legal words are
// registered and issued with a one-cycle start pulse. The arbiter then waits
// for the serializer busy flag to rise and fall before it grants again.
// Optional feature: define SERIALIZER_ARB_STAT_EN to add a saturating
// 16-bit counter of dropped words on drop_cnt_o.
module serializer_arbiter #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_W     = 16,
    parameter int DATA_MOD_W = 4
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [REQ_NUM*DATA_W-1:0]     req_data_i,
    input  logic [REQ_NUM*DATA_MOD_W-1:0] req_mod_i,
    input  logic [REQ_NUM-1:0]            req_val_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    output logic [DATA_W-1:0]             ser_data_o,
    output logic [DATA_MOD_W-1:0]         ser_mod_o,
    output logic                          ser_val_o,
    input  logic                          ser_busy_i,
    output logic [$clog2(REQ_NUM)-1:0]    grant_id_o,
    output logic                          busy_o
`ifdef SERIALIZER_ARB_STAT_EN
    ,
    output logic [15:0]                   drop_cnt_o
`endif
);

    localparam int IDW = $clog2(REQ_NUM);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_MOD_W-1:0] mod_q, mod_d;
    logic [IDW-1:0]        gid_q, gid_d;
    logic                  sval_q, sval_d;

    logic                  gnt_found;
    logic [IDW-1:0]        gnt_idx;
    logic [DATA_W-1:0]     sel_data;
    logic [DATA_MOD_W-1:0] sel_mod;
    logic                  accept;
    logic                  mod_illegal;
    int                    k;

    // Round-robin search from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        k         = 0;
        for (int i = 0; i < REQ_NUM; i++) begin
            k = int'(rr_ptr_q) + i;
            if (k >= REQ_NUM) k = k - REQ_NUM;
            if (!gnt_found && req_val_i[IDW'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(k);
            end
        end
    end

    // Mux out the granted word and drive the one-hot accept strobe.
    always_comb begin
        sel_data    = '0;
        sel_mod     = '0;
        req_ready_o = '0;
        accept      = (state_q == ST_IDLE) && gnt_found && !srst_i;
        for (int r = 0; r < REQ_NUM; r++) begin
            if (IDW'(r) == gnt_idx) begin
                sel_data       = req_data_i[r*DATA_W +: DATA_W];
                sel_mod        = req_mod_i[r*DATA_MOD_W +: DATA_MOD_W];
                req_ready_o[r] = accept;
            end
        end
        mod_illegal = (sel_mod == DATA_MOD_W'(1)) || (sel_mod == DATA_MOD_W'(2));
    end

    // Next-state logic: grant in IDLE, pulse in ISSUE, then track busy high/low.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        mod_d    = mod_q;
        gid_d    = gid_q;
        sval_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_ptr_d = (gnt_idx == IDW'(REQ_NUM-1)) ? '0 : gnt_idx + 1'b1;
                    if (!mod_illegal) begin
                        data_d  = sel_data;
                        mod_d   = sel_mod;
                        gid_d   = gnt_idx;
                        sval_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (ser_busy_i)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!ser_busy_i) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any word in flight.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            data_q   <= '0;
            mod_q    <= '0;
            gid_q    <= '0;
            sval_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            mod_q    <= mod_d;
            gid_q    <= gid_d;
            sval_q   <= sval_d;
        end
    end

`ifdef SERIALIZER_ARB_STAT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of accepted-but-dropped words.
    always_ff @(posedge clk_i) begin
        if (srst_i)
            drop_cnt_q <= '0;
        else if (accept && mod_illegal && (drop_cnt_q != 16'hFFFF))
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign ser_data_o = data_q;
    assign ser_mod_o  = mod_q;
    assign ser_val_o  = sval_q;
    assign grant_id_o = gid_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule
